apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter_if.sv | 45 ++++
 rtl/apb_arbiter.sv | 125 ++++++++++++
 tb/tb_apb_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if: requester side and APB master side of the arbiter.
// master = arbiter view, slave = environment view.
interface apb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [3:0]              req_valid;
  logic [4*ADDR_WIDTH-1:0] req_addr;
  logic [3:0]              req_write;
  logic [4*DATA_WIDTH-1:0] req_wdata;
  logic [4*SW-1:0]         req_strb;
  logic [3:0]              req_done;
  logic [DATA_WIDTH-1:0]   req_rdata;

  logic                    m_transfer;
  logic                    m_psel1;
  logic [ADDR_WIDTH-1:0]   m_paddr;
  logic                    m_pwrite;
  logic [DATA_WIDTH-1:0]   m_pwdata;
  logic [SW-1:0]           m_pstrb;

  logic                    PENABLE;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    input  req_valid, req_addr, req_write,
    input  req_wdata, req_strb,
    input  PENABLE, PREADY, PRDATA,
    output req_done, req_rdata,
    output m_transfer, m_psel1, m_paddr,
    output m_pwrite, m_pwdata, m_pstrb
  );

  modport slave (
    output req_valid, req_addr, req_write,
    output req_wdata, req_strb,
    output PENABLE, PREADY, PRDATA,
    input  req_done, req_rdata,
    input  m_transfer, m_psel1, m_paddr,
    input  m_pwrite, m_pwdata, m_pstrb
  );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter: 4-way round-robin front end for one APB master.
// APB_ARB_PRIO0_EN: requester 0 strict priority, 1-3 round-robin.
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_arbiter_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] grant;
  logic [1:0] last_grant;
  logic [1:0] win;

`ifdef APB_ARB_PRIO0_EN
  logic [1:0] last_rr;
  logic [1:0] s3;
  logic [1:0] o3;
  logic [5:0] dbl3;
  logic [2:0] rot3;
  logic [2:0] sum3;

  // rotate over requesters 1-3 only; bit b of rot3 space is requester b+1
  always_comb begin
    s3   = (last_rr == 2'd3) ? 2'd0 : last_rr;
    dbl3 = {bus.req_valid[3:1], bus.req_valid[3:1]};
    rot3 = dbl3[s3 +: 3];
    priority case (1'b1)
      rot3[0]: o3 = 2'd0;
      rot3[1]: o3 = 2'd1;
      rot3[2]: o3 = 2'd2;
      default: o3 = 2'd0;
    endcase
    sum3 = {1'b0, s3} + {1'b0, o3};
    if (sum3 >= 3'd3) sum3 = sum3 - 3'd3;
    win = bus.req_valid[0] ? 2'd0 : 2'(sum3 + 3'd1);
  end
`else
  logic [1:0] start;
  logic [1:0] off;
  logic [7:0] dbl;
  logic [3:0] rot;

  // rot[j] is requester (start + j) mod 4
  always_comb begin
    start = last_grant + 2'd1;
    dbl   = {bus.req_valid, bus.req_valid};
    rot   = dbl[start +: 4];
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    win = start + off;
  end
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state          <= IDLE;
      grant          <= 2'd0;
      last_grant     <= 2'd3;
`ifdef APB_ARB_PRIO0_EN
      last_rr        <= 2'd3;
`endif
      bus.m_transfer <= 1'b0;
      bus.m_psel1    <= 1'b0;
      bus.m_paddr    <= '0;
      bus.m_pwrite   <= 1'b0;
      bus.m_pwdata   <= '0;
      bus.m_pstrb    <= '0;
      bus.req_done   <= '0;
      bus.req_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant          <= win;
            bus.m_paddr    <= bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_pwrite   <= bus.req_write[win];
            bus.m_pwdata   <= bus.req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            bus.m_pstrb    <= bus.req_strb[int'(win)*SW +: SW];
            bus.m_psel1    <= 1'b1;
            bus.m_transfer <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.m_transfer <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          // ready without enable is a setup-phase glitch, not a completion
          if (bus.PENABLE && bus.PREADY) begin
            if (!bus.m_pwrite) bus.req_rdata <= bus.PRDATA;
            bus.req_done <= 4'b0001 << grant;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.req_done <= '0;
          bus.m_psel1  <= 1'b0;
          last_grant   <= grant;
`ifdef APB_ARB_PRIO0_EN
          if (grant != 2'd0) last_rr <= grant;
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: scoreboard bench for apb_arbiter.
// Models the APB master phases and a reference arbiter.
module tb_apb_arbiter;
  logic PCLK;
  logic PRESET;

  apb_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          nchecks = 0;
  int          nerrors = 0;
  int          m_last = 3;
  int          m_last_rr = 3;
  logic [31:0] mdl_rdata = '0;

  logic [31:0] addr_t[4];
  logic [31:0] wdata_t[4];
  logic [3:0]  strb_t[4];
  logic        write_t[4];

  function automatic logic [1:0] pick(input logic [3:0] v);
`ifdef APB_ARB_PRIO0_EN
    if (v[0]) return 2'd0;
    for (int k = 1; k <= 3; k++) begin
      int r;
      r = ((m_last_rr - 1 + k) % 3) + 1;
      if (v[r]) return 2'(r);
    end
`else
    for (int k = 1; k <= 4; k++) begin
      int r;
      r = (m_last + k) % 4;
      if (v[r]) return 2'(r);
    end
`endif
    return 2'(m_last);
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*32 +: 32]  = addr_t[i];
      bus.req_wdata[i*32 +: 32] = wdata_t[i];
      bus.req_strb[i*4 +: 4]    = strb_t[i];
      bus.req_write[i]          = write_t[i];
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    m_last = 3;
    m_last_rr = 3;
    mdl_rdata = '0;
    sbq.delete();
  endtask

  // one complete transfer; APB master phases are modelled here
  task automatic xfer(input logic [3:0] v, input int waits,
                      input logic [31:0] prd, input logic spur,
                      output logic [3:0] got);
    exp_t       e;
    logic [1:0] w;
    logic       seen;
    logic       done;
    logic       bad;
    int         j;
    got = '0;
    bus.req_valid = v;
    drive_reqs();
    w = pick(v);
    e.idx = w;
    if (!write_t[w]) mdl_rdata = prd;
    e.rdata = mdl_rdata;
    sbq.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.m_transfer === 1'b1) seen = 1'b1;
    end
    nchecks++;
    if (!seen) begin
      nerrors++;
      $display("FAIL grant_timeout: m_transfer=%b required 1", bus.m_transfer);
      void'(sbq.pop_front());
      return;
    end
    nchecks++;
    if (bus.m_psel1 !== 1'b1 || bus.m_paddr !== addr_t[w] ||
        bus.m_pwrite !== write_t[w] || bus.m_pwdata !== wdata_t[w] ||
        bus.m_pstrb !== strb_t[w]) begin
      nerrors++;
      $display("FAIL issue_fields: psel=%b addr=%h wr=%b wd=%h st=%h required 1 %h %b %h %h",
               bus.m_psel1, bus.m_paddr, bus.m_pwrite, bus.m_pwdata,
               bus.m_pstrb, addr_t[w], write_t[w], wdata_t[w], strb_t[w]);
    end
    @(negedge PCLK);
    bus.PENABLE = 1'b0;
    bus.PREADY = spur;
    nchecks++;
    if (bus.m_transfer !== 1'b0) begin
      nerrors++;
      $display("FAIL transfer_pulse: m_transfer=%b required 0", bus.m_transfer);
    end
    @(negedge PCLK);
    nchecks++;
    if (bus.req_done !== 4'b0000) begin
      nerrors++;
      $display("FAIL early_done: req_done=%b required 0000", bus.req_done);
    end
    bus.PENABLE = 1'b1;
    bus.PREADY = (waits == 0);
    bus.PRDATA = prd;
    bad = 1'b0;
    done = 1'b0;
    j = 0;
    while (!done && j < waits + 8) begin
      @(negedge PCLK);
      j++;
      if (bus.m_transfer !== 1'b0 || bus.m_psel1 !== 1'b1 ||
          bus.m_paddr !== addr_t[w] || bus.m_pwrite !== write_t[w] ||
          bus.m_pwdata !== wdata_t[w] || bus.m_pstrb !== strb_t[w])
        bad = 1'b1;
      if (bus.req_done !== 4'b0000) done = 1'b1;
      else bus.PREADY = (j >= waits);
    end
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0;
    nchecks++;
    if (!done) begin
      nerrors++;
      $display("FAIL done_timeout: req_done=%b required one-hot", bus.req_done);
      void'(sbq.pop_front());
      return;
    end
    got = bus.req_done;
    e = sbq.pop_front();
    nchecks++;
    if (j + 2 != 3 + waits) begin
      nerrors++;
      $display("FAIL done_latency: %0d cycles required %0d", j + 2, 3 + waits);
    end
    nchecks++;
    if (bus.req_done !== 4'(1 << e.idx)) begin
      nerrors++;
      $display("FAIL done_grant: req_done=%b required %b",
               bus.req_done, 4'(1 << e.idx));
    end
    nchecks++;
    if (bus.req_rdata !== e.rdata) begin
      nerrors++;
      $display("FAIL rdata: req_rdata=%h required %h", bus.req_rdata, e.rdata);
    end
    nchecks++;
    if (bad) begin
      nerrors++;
      $display("FAIL m_stable: bus fields moved, actual addr=%h required %h",
               bus.m_paddr, addr_t[w]);
    end
    m_last = int'(e.idx);
    if (e.idx != 2'd0) m_last_rr = int'(e.idx);
    @(negedge PCLK);
    nchecks++;
    if (bus.req_done !== 4'b0000 || bus.m_psel1 !== 1'b0) begin
      nerrors++;
      $display("FAIL done_release: req_done=%b psel=%b required 0000 0",
               bus.req_done, bus.m_psel1);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    nchecks++;
    if (bus.m_transfer !== 1'b0 || bus.m_psel1 !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_ctl: transfer=%b psel=%b required 0 0",
               bus.m_transfer, bus.m_psel1);
    end
    nchecks++;
    if (bus.m_paddr !== '0 || bus.m_pwrite !== 1'b0 ||
        bus.m_pwdata !== '0 || bus.m_pstrb !== '0) begin
      nerrors++;
      $display("FAIL reset_bus: addr=%h wd=%h required 0 0",
               bus.m_paddr, bus.m_pwdata);
    end
    nchecks++;
    if (bus.req_done !== 4'b0000 || bus.req_rdata !== '0) begin
      nerrors++;
      $display("FAIL reset_req: done=%b rdata=%h required 0 0",
               bus.req_done, bus.req_rdata);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] got;
    xfer(4'b0010, 0, 32'h0, 1'b0, got);
    bus.req_valid = '0;
  endtask

  task automatic test_read_wait();
    logic [3:0] got;
    xfer(4'b0100, 3, 32'h1234_5678, 1'b0, got);
    bus.req_valid = '0;
  endtask

  task automatic test_spurious();
    logic [3:0] got;
    xfer(4'b1000, 2, 32'hCAFE_F00D, 1'b1, got);
    bus.req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] got;
    int         ex;
    do_reset();
    for (int i = 0; i < 8; i++) begin
`ifdef APB_ARB_PRIO0_EN
      ex = 0;
`else
      ex = i % 4;
`endif
      xfer(4'hF, i % 2, 32'hA000_0000 + 32'(i), 1'b0, got);
      nchecks++;
      if (got !== 4'(1 << ex)) begin
        nerrors++;
        $display("FAIL fair_order[%0d]: req_done=%b required %b",
                 i, got, 4'(1 << ex));
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_skip();
    logic [3:0] got;
    logic [3:0] ex;
    xfer(4'b1010, 0, 32'h5555_0001, 1'b0, got);
    nchecks++;
    if (got !== 4'b0010) begin
      nerrors++;
      $display("FAIL skip_a: req_done=%b required 0010", got);
    end
`ifdef APB_ARB_PRIO0_EN
    ex = 4'b0001;
`else
    ex = 4'b1000;
`endif
    xfer(4'b1001, 1, 32'h5555_0002, 1'b0, got);
    nchecks++;
    if (got !== ex) begin
      nerrors++;
      $display("FAIL skip_b: req_done=%b required %b", got, ex);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] got;
    logic       seen;
    logic       bad;
    bus.req_valid = 4'b0100;
    drive_reqs();
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.m_transfer === 1'b1) seen = 1'b1;
    end
    nchecks++;
    if (!seen) begin
      nerrors++;
      $display("FAIL rst_grant_timeout: m_transfer=%b required 1",
               bus.m_transfer);
    end
    @(negedge PCLK);
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.req_valid = '0;
    m_last = 3;
    m_last_rr = 3;
    mdl_rdata = '0;
    sbq.delete();
    nchecks++;
    if (bus.m_transfer !== 1'b0 || bus.m_psel1 !== 1'b0 ||
        bus.m_paddr !== '0 || bus.m_pwdata !== '0 ||
        bus.m_pstrb !== '0 || bus.m_pwrite !== 1'b0) begin
      nerrors++;
      $display("FAIL rst_mid_bus: psel=%b addr=%h required 0 0",
               bus.m_psel1, bus.m_paddr);
    end
    nchecks++;
    if (bus.req_done !== 4'b0000 || bus.req_rdata !== '0) begin
      nerrors++;
      $display("FAIL rst_mid_req: done=%b rdata=%h required 0 0",
               bus.req_done, bus.req_rdata);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      if (bus.req_done !== 4'b0000 || bus.m_transfer !== 1'b0) bad = 1'b1;
    end
    nchecks++;
    if (bad) begin
      nerrors++;
      $display("FAIL rst_no_done: req_done=%b required 0000", bus.req_done);
    end
    xfer(4'hF, 0, 32'h0BAD_CAFE, 1'b0, got);
    nchecks++;
    if (got !== 4'b0001) begin
      nerrors++;
      $display("FAIL rst_next_grant: req_done=%b required 0001", got);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.req_strb = '0;
    bus.PENABLE = 1'b0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    addr_t[0] = 32'h0000_0040;
    addr_t[1] = 32'h0000_0100;
    addr_t[2] = 32'h0000_0020;
    addr_t[3] = 32'h0000_03C0;
    wdata_t[0] = 32'h1111_2222;
    wdata_t[1] = 32'hDEAD_BEEF;
    wdata_t[2] = 32'h0;
    wdata_t[3] = 32'h0;
    strb_t[0] = 4'b0011;
    strb_t[1] = 4'hF;
    strb_t[2] = 4'h0;
    strb_t[3] = 4'h0;
    write_t[0] = 1'b1;
    write_t[1] = 1'b1;
    write_t[2] = 1'b0;
    write_t[3] = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_spurious();
    test_fairness();
    test_skip();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
